// File: rtl/imm_gen_stage.sv
// -----------------------------------------------------------------------------
// imm_gen_stage
//   Registered immediate generator that sits between fetch/decode and execute.
//   The immediate format is decoded from the opcode itself. The immediate is
//   extended to XLEN and returned together with its type code, an illegal flag
//   and an unmodified sideband tag (normally the PC). A 2-entry skid buffer
//   (main register M, skid register K) decouples upstream and downstream
//   handshakes. A synchronous flush drops every buffered entry.
//
// Handshake (both sides): a transfer happens on a rising edge where valid and
//   ready are both high. A producer holding valid keeps its payload stable
//   until the transfer. o_ready is a flop output and never depends
//   combinationally on i_ready.
//
// Parameters
//   XLEN   result width, 32 or 64
//   TAG_W  width of the sideband tag
//   ZIMM   1: SYSTEM with funct3[2]=1 decodes as Z (5-bit uimm)
//          0: decodes as zero-extended I (CSR address)
//
// Ports
//   i_clk, i_rst       clock (rising edge), synchronous active-high reset
//   i_flush            synchronous flush, drops all buffered entries
//   i_valid, o_ready   upstream handshake
//   i_instr, i_tag     upstream payload (instruction word, sideband tag)
//   o_valid, i_ready   downstream handshake
//   o_imm              extended immediate
//   o_imm_type         0=I 1=S 2=B 3=J 4=U 5=Z 7=none
//   o_illegal          opcode has no immediate decode
//   o_tag              tag belonging to o_imm
// -----------------------------------------------------------------------------
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int ZIMM  = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_imm,
  output logic [2:0]       o_imm_type,
  output logic             o_illegal,
  output logic [TAG_W-1:0] o_tag
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_stage: XLEN must be 32 or 64");
    end
  endgenerate

  localparam logic [2:0] TYPE_I    = 3'd0;
  localparam logic [2:0] TYPE_S    = 3'd1;
  localparam logic [2:0] TYPE_B    = 3'd2;
  localparam logic [2:0] TYPE_J    = 3'd3;
  localparam logic [2:0] TYPE_U    = 3'd4;
  localparam logic [2:0] TYPE_Z    = 3'd5;
  localparam logic [2:0] TYPE_NONE = 3'd7;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_type;
  logic            dec_illegal;

  always_comb begin
    dec_imm     = '0;
    dec_type    = TYPE_NONE;
    dec_illegal = 1'b0;
    case (i_instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
        dec_imm  = XLEN'($signed(i_instr[31:20]));
        dec_type = TYPE_I;
      end
      OPC_STORE: begin
        dec_imm  = XLEN'($signed({i_instr[31:25], i_instr[11:7]}));
        dec_type = TYPE_S;
      end
      OPC_BRANCH: begin
        dec_imm  = XLEN'($signed({i_instr[31], i_instr[7], i_instr[30:25],
                                  i_instr[11:8], 1'b0}));
        dec_type = TYPE_B;
      end
      OPC_JAL: begin
        dec_imm  = XLEN'($signed({i_instr[31], i_instr[19:12], i_instr[20],
                                  i_instr[30:21], 1'b0}));
        dec_type = TYPE_J;
      end
      OPC_LUI, OPC_AUIPC: begin
        // Sign extension only has an effect when XLEN=64.
        dec_imm  = XLEN'($signed({i_instr[31:12], 12'b0}));
        dec_type = TYPE_U;
      end
      OPC_SYSTEM: begin
        if (i_instr[14] && (ZIMM != 0)) begin
          dec_imm  = XLEN'(i_instr[19:15]);
          dec_type = TYPE_Z;
        end else begin
          // CSR address: an index, so zero-extended.
          dec_imm  = XLEN'(i_instr[31:20]);
          dec_type = TYPE_I;
        end
      end
      OPC_OP, OPC_FENCE: begin
        dec_type = TYPE_NONE;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Skid buffer: M drives the outputs, K catches an accept while M is held.
  // Invariant: K is only ever valid while M is valid, and ready_q == !k_valid.
  // ---------------------------------------------------------------------------
  logic             m_valid;
  logic [XLEN-1:0]  m_imm;
  logic [2:0]       m_type;
  logic             m_illegal;
  logic [TAG_W-1:0] m_tag;

  logic             k_valid;
  logic [XLEN-1:0]  k_imm;
  logic [2:0]       k_type;
  logic             k_illegal;
  logic [TAG_W-1:0] k_tag;

  logic             ready_q;
  logic             accept;
  logic             m_free;

  assign accept = i_valid & ready_q;
  // M can take new content when it is empty or is delivered this cycle.
  assign m_free = ~m_valid | i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      m_valid   <= 1'b0;
      m_imm     <= '0;
      m_type    <= '0;
      m_illegal <= 1'b0;
      m_tag     <= '0;
      k_valid   <= 1'b0;
      k_imm     <= '0;
      k_type    <= '0;
      k_illegal <= 1'b0;
      k_tag     <= '0;
      ready_q   <= 1'b1;
    end else if (i_flush) begin
      // Data registers keep their stale contents; only the valid bits matter.
      m_valid <= 1'b0;
      k_valid <= 1'b0;
      ready_q <= 1'b1;
    end else if (m_free) begin
      if (k_valid) begin
        // ready_q was low, so no accept can coincide with this move.
        m_valid   <= 1'b1;
        m_imm     <= k_imm;
        m_type    <= k_type;
        m_illegal <= k_illegal;
        m_tag     <= k_tag;
        k_valid   <= 1'b0;
        ready_q   <= 1'b1;
      end else if (accept) begin
        m_valid   <= 1'b1;
        m_imm     <= dec_imm;
        m_type    <= dec_type;
        m_illegal <= dec_illegal;
        m_tag     <= i_tag;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (accept) begin
      // M is held by the consumer: park the new entry in K and stop upstream.
      k_valid   <= 1'b1;
      k_imm     <= dec_imm;
      k_type    <= dec_type;
      k_illegal <= dec_illegal;
      k_tag     <= i_tag;
      ready_q   <= 1'b0;
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = m_valid;
  assign o_imm      = m_imm;
  assign o_imm_type = m_type;
  assign o_illegal  = m_illegal;
  assign o_tag      = m_tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_stage
//   Two instances share every input: dut_a (XLEN=32, ZIMM=1) and
//   dut_b (XLEN=64, ZIMM=0). Directed vector table, hand-written stall /
//   flush / reset sequences, then randomized traffic scored against a
//   reference decoder built from integer arithmetic.
// -----------------------------------------------------------------------------
module tb_imm_gen_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        valid;
  logic        rdy_in;
  logic [31:0] instr;
  logic [31:0] tag;

  logic        a_ready, a_valid, a_illegal;
  logic [31:0] a_imm;
  logic [2:0]  a_type;
  logic [31:0] a_tag;

  logic        b_ready, b_valid, b_illegal;
  logic [63:0] b_imm;
  logic [2:0]  b_type;
  logic [31:0] b_tag;

  imm_gen_stage #(.XLEN(32), .TAG_W(32), .ZIMM(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid),
    .o_ready(a_ready), .i_instr(instr), .i_tag(tag), .o_valid(a_valid),
    .i_ready(rdy_in), .o_imm(a_imm), .o_imm_type(a_type),
    .o_illegal(a_illegal), .o_tag(a_tag)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(32), .ZIMM(0)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid),
    .o_ready(b_ready), .i_instr(instr), .i_tag(tag), .o_valid(b_valid),
    .i_ready(rdy_in), .o_imm(b_imm), .o_imm_type(b_type),
    .o_illegal(b_illegal), .o_tag(b_tag)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];     // {tag, instr} of entries accepted, not yet delivered
  logic [31:0] got_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference decoder: field values assembled with integer arithmetic and
  // sign handled by subtracting 2^width when the top bit is set.
  function automatic void ref_decode(input logic [31:0] ins, input bit zimm,
                                     output longint v, output logic [2:0] ty,
                                     output logic ill);
    longint w;
    w   = longint'({32'd0, ins});
    v   = 0;
    ty  = 3'd7;
    ill = 1'b0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: begin
        v = w >> 20;
        if (v >= 2048) v = v - 4096;
        ty = 3'd0;
      end
      7'h23: begin
        v = ((w >> 25) * 32) + ((w >> 7) & 31);
        if (v >= 2048) v = v - 4096;
        ty = 3'd1;
      end
      7'h63: begin
        v = ((w >> 31) & 1) * 4096 + ((w >> 7) & 1) * 2048 +
            ((w >> 25) & 63) * 32 + ((w >> 8) & 15) * 2;
        if (v >= 4096) v = v - 8192;
        ty = 3'd2;
      end
      7'h6F: begin
        v = ((w >> 31) & 1) * 1048576 + ((w >> 12) & 255) * 4096 +
            ((w >> 20) & 1) * 2048 + ((w >> 21) & 1023) * 2;
        if (v >= 1048576) v = v - 2097152;
        ty = 3'd3;
      end
      7'h37, 7'h17: begin
        v = (w >> 12) * 4096;
        if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
        ty = 3'd4;
      end
      7'h73: begin
        if ((((w >> 14) & 1) == 1) && zimm) begin
          v  = (w >> 15) & 31;
          ty = 3'd5;
        end else begin
          v  = w >> 20;
          ty = 3'd0;
        end
      end
      7'h33, 7'h0F: ty = 3'd7;
      default: ill = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[11];
    logic [31:0] r;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h33, 7'h0F};
    r = $urandom();
    if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 10)];
    return r;
  endfunction

  // Compare both instances' outputs against the model result for one entry.
  task automatic check_entry(input string name, input logic [31:0] ins, input logic [31:0] tg);
    longint     v;
    logic [2:0] ty;
    logic       ill;
    ref_decode(ins, 1'b1, v, ty, ill);
    check({name, "_a_imm"}, {32'd0, a_imm}, {32'd0, v[31:0]});
    check({name, "_a_type"}, {61'd0, a_type}, {61'd0, ty});
    check({name, "_a_ill"}, {63'd0, a_illegal}, {63'd0, ill});
    check({name, "_a_tag"}, {32'd0, a_tag}, {32'd0, tg});
    ref_decode(ins, 1'b0, v, ty, ill);
    check({name, "_b_imm"}, b_imm, v);
    check({name, "_b_type"}, {61'd0, b_type}, {61'd0, ty});
    check({name, "_b_ill"}, {63'd0, b_illegal}, {63'd0, ill});
    check({name, "_b_tag"}, {32'd0, b_tag}, {32'd0, tg});
  endtask

  task automatic check_hs(input string name, input logic exp_valid, input logic exp_ready);
    check({name, "_a_valid"}, {63'd0, a_valid}, {63'd0, exp_valid});
    check({name, "_a_ready"}, {63'd0, a_ready}, {63'd0, exp_ready});
    check({name, "_b_valid"}, {63'd0, b_valid}, {63'd0, exp_valid});
    check({name, "_b_ready"}, {63'd0, b_ready}, {63'd0, exp_ready});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] ins;
    logic [31:0] imm_a;   // XLEN=32, ZIMM=1
    logic [2:0]  ty_a;
    logic [63:0] imm_b;   // XLEN=64, ZIMM=0
    logic [2:0]  ty_b;
    logic        ill;
  } vec_t;

  vec_t vecs[16];

  initial begin
    bit sent3;

    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd0, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0};
    vecs[1]  = '{32'h00112623, 32'h0000000C, 3'd1, 64'h000000000000000C, 3'd1, 1'b0};
    vecs[2]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd2, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
    vecs[3]  = '{32'h800000B7, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    vecs[4]  = '{32'h0080006F, 32'h00000008, 3'd3, 64'h0000000000000008, 3'd3, 1'b0};
    vecs[5]  = '{32'h300FD073, 32'h0000001F, 3'd5, 64'h0000000000000300, 3'd0, 1'b0};
    vecs[6]  = '{32'h0000007F, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd7, 1'b1};
    vecs[7]  = '{32'h00000033, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd7, 1'b0};
    vecs[8]  = '{32'h0000000F, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd7, 1'b0};
    vecs[9]  = '{32'h12345017, 32'h12345000, 3'd4, 64'h0000000012345000, 3'd4, 1'b0};
    vecs[10] = '{32'hF1402573, 32'h00000F14, 3'd0, 64'h0000000000000F14, 3'd0, 1'b0};
    vecs[11] = '{32'h80002083, 32'hFFFFF800, 3'd0, 64'hFFFFFFFFFFFFF800, 3'd0, 1'b0};
    vecs[12] = '{32'h7FF00067, 32'h000007FF, 3'd0, 64'h00000000000007FF, 3'd0, 1'b0};
    vecs[13] = '{32'hFE112E23, 32'hFFFFFFFC, 3'd1, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0};
    vecs[14] = '{32'hFFDFF0EF, 32'hFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
    vecs[15] = '{32'hFFFFFFFF, 32'h00000000, 3'd7, 64'h0000000000000000, 3'd7, 1'b1};

    rst = 1'b1; flush = 1'b0; valid = 1'b0; rdy_in = 1'b1; instr = '0; tag = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check_hs("reset", 1'b0, 1'b1);
    check("reset_a_imm", {32'd0, a_imm}, 64'd0);
    check("reset_b_imm", b_imm, 64'd0);
    check("reset_a_tag", {32'd0, a_tag}, 64'd0);
    rst = 1'b0;

    // Back-to-back table, i_ready=1: entry i is checked one cycle after it is offered.
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check("vec_a_valid", {63'd0, a_valid}, 64'd1);
        check($sformatf("vec%0d_a_imm", i - 1), {32'd0, a_imm}, {32'd0, vecs[i-1].imm_a});
        check($sformatf("vec%0d_a_type", i - 1), {61'd0, a_type}, {61'd0, vecs[i-1].ty_a});
        check($sformatf("vec%0d_a_ill", i - 1), {63'd0, a_illegal}, {63'd0, vecs[i-1].ill});
        check($sformatf("vec%0d_a_tag", i - 1), {32'd0, a_tag}, 64'(i + 99));
        check($sformatf("vec%0d_b_imm", i - 1), b_imm, vecs[i-1].imm_b);
        check($sformatf("vec%0d_b_type", i - 1), {61'd0, b_type}, {61'd0, vecs[i-1].ty_b});
        check($sformatf("vec%0d_b_ill", i - 1), {63'd0, b_illegal}, {63'd0, vecs[i-1].ill});
      end
      if (i < 16) begin
        valid = 1'b1; instr = vecs[i].ins; tag = 32'(i + 100);
      end else begin
        valid = 1'b0;
      end
    end
    @(negedge clk);
    check_hs("drain", 1'b0, 1'b1);

    // Stall: tags 1,2 accepted, tag 3 held upstream, then all drain in order.
    rdy_in = 1'b0; valid = 1'b1; instr = 32'h00000013; tag = 32'd1;
    @(negedge clk); tag = 32'd2;
    @(negedge clk);
    check_hs("stall_full", 1'b1, 1'b0);
    tag = 32'd3; instr = 32'hFFF00093;
    @(negedge clk);
    check_hs("stall_hold", 1'b1, 1'b0);
    check("stall_hold_tag", {32'd0, a_tag}, 64'd1);
    check("stall_hold_imm", {32'd0, a_imm}, 64'd0);
    got_q.delete();
    sent3 = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rdy_in = 1'b1;
      if (sent3) valid = 1'b0;
      if (a_valid && rdy_in) got_q.push_back(a_tag);
      if (valid && a_ready) sent3 = 1'b1;
    end
    check("stall_drain_count", 64'(got_q.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < got_q.size()) check($sformatf("stall_order%0d", i), {32'd0, got_q[i]}, 64'(i + 1));
    check_hs("stall_after", 1'b0, 1'b1);

    // Flush with two entries buffered and an entry offered.
    rdy_in = 1'b0; valid = 1'b1; tag = 32'h10;
    @(negedge clk); tag = 32'h11;
    @(negedge clk);
    check_hs("flush_pre", 1'b1, 1'b0);
    flush = 1'b1; tag = 32'h12;
    @(negedge clk);
    check_hs("flush_full", 1'b0, 1'b1);
    flush = 1'b0; valid = 1'b0; rdy_in = 1'b1;
    repeat (2) @(negedge clk);
    check_hs("flush_quiet", 1'b0, 1'b1);

    // Flush with one entry and o_ready high: the offered entry is discarded.
    rdy_in = 1'b0; valid = 1'b1; tag = 32'h13;
    @(negedge clk);
    flush = 1'b1; tag = 32'h14;
    @(negedge clk);
    check_hs("flush_accept", 1'b0, 1'b1);
    flush = 1'b0; valid = 1'b0; rdy_in = 1'b1;
    @(negedge clk);
    check_hs("flush_accept_quiet", 1'b0, 1'b1);

    // Reset while stalled and full, with a flush also asserted.
    rdy_in = 1'b0; valid = 1'b1; instr = 32'hFFF00093; tag = 32'h20;
    @(negedge clk); tag = 32'h21;
    @(negedge clk);
    check_hs("rst_pre", 1'b1, 1'b0);
    rst = 1'b1; flush = 1'b1;
    @(negedge clk);
    check_hs("rst_mid", 1'b0, 1'b1);
    check("rst_mid_a_imm", {32'd0, a_imm}, 64'd0);
    check("rst_mid_b_imm", b_imm, 64'd0);
    check("rst_mid_tag", {32'd0, a_tag}, 64'd0);
    check("rst_mid_type", {61'd0, a_type}, 64'd0);
    rst = 1'b0; flush = 1'b0; rdy_in = 1'b1; instr = 32'h0080006F; tag = 32'h77;
    @(negedge clk);
    valid = 1'b0;
    check_hs("rst_resume", 1'b1, 1'b1);
    check_entry("rst_resume", 32'h0080006F, 32'h77);
    @(negedge clk);
    check_hs("rst_resume_empty", 1'b0, 1'b1);

    // Randomized traffic against the reference model.
    exp_q.delete();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      valid  = ($urandom_range(0, 3) != 0);
      instr  = rand_instr();
      tag    = $urandom();
      rdy_in = ($urandom_range(0, 1) != 0);
      flush  = ($urandom_range(0, 31) == 0);
      check_hs("rnd", exp_q.size() != 0, exp_q.size() < 2);
      if (exp_q.size() != 0) begin
        check_entry("rnd", exp_q[0][31:0], exp_q[0][63:32]);
        if (rdy_in) void'(exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      else if (valid && a_ready) exp_q.push_back({tag, instr});
    end
    @(negedge clk);
    valid = 1'b0; flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
